decode_shift: RTL and testbench
===============================

# decode_shift

Bit-stream aligner feeding `decode_ctl`. It accepts 32-bit compressed words, MSB-first, from a show-ahead input FIFO. It presents the next 13 unconsumed bits as `stream_data[12:0]` and retires `stream_width` bits whenever `decode_ctl` asserts `stream_ack`. It owns refill scheduling, end-of-stream tail padding and flushing when `all_end` is raised.

## Interface
- No parameters. Buffer is fixed at 64 bits, word width at 32, window at 13.
- One clock. Reset is synchronous and active-high. Ports are named `clk` and `rst`.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `ce_decode` in 1: level enable; a rising use starts a stream.
- `in_data` in 32: FIFO head word, MSB is the first stream bit.
- `in_valid` in 1: FIFO not empty.
- `in_last` in 1: qualifies `in_data` as the final word of the stream.
- `in_ack` out 1: FIFO read strobe; the word is consumed in the same cycle.
- `stream_width` in 4: bits to retire; valid values are 0..13.
- `stream_ack` in 1: retire `stream_width` bits (combinational from `decode_ctl`).
- `all_end` in 1: `decode_ctl` has reached END.
- `stream_data` out 13: registered window = `buf[63:51]`.
- `stream_valid` out 1: registered; the window holds usable bits.
- `stream_err` out 1: sticky illegal-width flag.
- `bit_total` out 32: bits consumed (see Configuration).

## Operation
- State: `buf[63:0]` (left-aligned, zero-filled below valid bits), `cnt[6:0]` (0..64).
- FSM states:
  - S_IDLE: `buf`=0, `cnt`=0, `in_ack`=0. Go to S_RUN when `ce_decode`=1.
  - S_RUN: refill allowed. Go to S_DRAIN in the cycle a word with `in_last`=1 is accepted.
  - S_DRAIN: no refill; remaining bits are consumed.
  - S_DONE: hold; `stream_valid`=0. Go to S_IDLE when `ce_decode`=0.
- `all_end`=1 in S_RUN or S_DRAIN: go to S_DONE next cycle, clear `buf` and `cnt`, and discard any unread FIFO data.
- Consume: when `stream_ack` && `stream_valid` && `stream_width`<=13, compute `buf' = buf << width` and `cnt' = cnt - width`. `stream_width`=0 is a no-op.
- Illegal width: `stream_ack` with `stream_width` 14 or 15 sets `stream_err` (sticky until S_IDLE) and consumes nothing.
- Consuming more than `cnt` bits in S_DRAIN clamps `cnt'` to 0.
- Refill: `in_ack = (state==S_RUN) && in_valid && (cnt' <= 32)`, where `cnt'` is the post-consume count. The accepted word is OR'd into `buf'` at bit positions `[63-cnt' : 32-cnt']`, and `cnt'' = cnt' + 32`.
- Consume and refill happen in the same cycle.
- `stream_valid_next` = (`cnt''` >= 13) || (state is S_DRAIN, or S_RUN accepting the last word, and `cnt''` > 0).
- In S_DRAIN the window is zero-padded below `cnt`.

## Timing
- Reset values: state=S_IDLE, `buf`=0, `cnt`=0, `stream_data`=0, `stream_valid`=0, `stream_err`=0, `bit_total`=0. `in_ack`=0 (combinational, S_IDLE).
- `stream_ack` sampled at edge k: the updated `stream_data`/`stream_valid` are visible after edge k, i.e. in cycle k+1. There is no bubble between back-to-back acks.
- Start-up latency: `ce_decode` high in cycle N with `in_valid`=1 gives `in_ack` in N+1, and the first `stream_valid`=1 in N+2.
- `in_ack` is combinational from registered state, `stream_ack` and `stream_width`. `stream_data` and `stream_valid` are never combinational, so the loop with `decode_ctl` stays registered.
- `rst` in any cycle overrides every other input. The FIFO contents are not this block's responsibility.

## Configuration
- `DECODE_SHIFT_STAT_EN` defined:
  - `bit_total` is a 32-bit counter that adds each legal consumed width.
  - It saturates at 0xFFFFFFFF.
  - It clears in S_IDLE and on `rst`.
- `DECODE_SHIFT_STAT_EN` undefined: `bit_total` is tied to 0 and no counter logic is built.

## Test plan
- Basic window: `ce_decode`=1, in words 0x12345678 then 0x9ABCDEF0 -> `stream_data`=0x0246. After ack with width 9 -> `stream_data`=0x0D15.
- END word: 0xC0000000 with `in_last`=1 -> `stream_valid`=1, `stream_data`=0x1800. Then `all_end`=1 -> S_DONE, `stream_valid`=0, `in_ack` stays 0.
- Refill straddle: 3 words with continuous acks of width 13 -> `in_ack` pulses exactly when `cnt'`<=32, no bubble in `stream_valid`, bit order preserved across the word seams.
- Tail: single word 0xFFFFFFFF with `in_last`, acks of 13 and 13 -> window=0x1F80 (6 ones, zero-padded), `stream_valid`=1. Ack 6 -> `stream_valid`=0. `bit_total`=32 when `DECODE_SHIFT_STAT_EN` is defined.
- Illegal width: ack with width 14 -> `stream_err`=1, `stream_data` unchanged, `bit_total` unchanged.
- Reset mid-stream: `rst` pulsed during S_RUN with `cnt`=40 -> next cycle all outputs at reset values. Restart with `ce_decode` delivers a correct first window.

Source files
------------

// File: rtl/decode_shift_if.sv
// -----------------------------------------------------------------------------
// decode_shift_if
// Bundles the FIFO-side and decoder-side signals of the decode_shift bit aligner.
//
// Signals:
//   ce_decode     : level enable, a rising edge starts a stream
//   in_data       : FIFO head word, MSB is the first stream bit
//   in_valid      : FIFO not empty
//   in_last       : head word is the last word of the stream
//   in_ack        : FIFO read strobe (word consumed in the same cycle)
//   stream_width  : number of bits to retire (0..13 legal)
//   stream_ack    : retire stream_width bits
//   all_end       : decoder has reached its END state
//   stream_data   : 13-bit registered window of the next unconsumed bits
//   stream_valid  : window holds usable bits
//   stream_err    : sticky illegal-width flag
//   bit_total     : consumed-bit counter (zero unless statistics are built)
//
// Modports:
//   master : decoder / FIFO side (drives ce, data, acks)
//   slave  : decode_shift itself
// -----------------------------------------------------------------------------
interface decode_shift_if;
    logic        ce_decode;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ack;
    logic [3:0]  stream_width;
    logic        stream_ack;
    logic        all_end;
    logic [12:0] stream_data;
    logic        stream_valid;
    logic        stream_err;
    logic [31:0] bit_total;

    modport master (
        output ce_decode, in_data, in_valid, in_last,
        output stream_width, stream_ack, all_end,
        input  in_ack, stream_data, stream_valid, stream_err, bit_total
    );

    modport slave (
        input  ce_decode, in_data, in_valid, in_last,
        input  stream_width, stream_ack, all_end,
        output in_ack, stream_data, stream_valid, stream_err, bit_total
    );
endinterface

// File: rtl/decode_shift.sv
// -----------------------------------------------------------------------------
// decode_shift
// MSB-first bit-stream aligner. Holds up to 64 bits left-aligned in r_buf,
// presents the top 13 bits as stream_data, retires stream_width bits per
// stream_ack, refills 32-bit words from a show-ahead FIFO whenever the
// post-consume count leaves room, and zero-pads the tail after the last word.
//
// Ports:
//   clk     : clock
//   rst     : synchronous active-high reset
//   io_bus  : decode_shift_if.slave (FIFO + decoder handshake, see interface)
//
// Build option:
//   DECODE_SHIFT_STAT_EN : when defined, bit_total counts consumed bits
//                          (saturating); otherwise bit_total is tied to 0.
// -----------------------------------------------------------------------------
module decode_shift (
    input  logic           clk,
    input  logic           rst,
    decode_shift_if.slave  io_bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t      r_state, w_state_next;
    logic [63:0] r_buf, w_buf_cons, w_buf_next;
    logic [6:0]  r_cnt, w_cnt_cons, w_cnt_next;
    logic        r_valid, w_valid_next;
    logic        r_err, w_err_next;
    logic        w_active, w_consume, w_illegal, w_in_ack, w_last_acc;
    logic [6:0]  w_width_ext;

    assign w_width_ext = {3'b000, io_bus.stream_width};

    // Consume step: shift out the retired bits. In the drain phase the
    // decoder may ask for more than remain, so the count clamps at zero.
    always_comb begin
        w_active   = (r_state == S_RUN) || (r_state == S_DRAIN);
        w_consume  = w_active && io_bus.stream_ack && r_valid &&
                     (io_bus.stream_width <= 4'd13);
        w_illegal  = w_active && io_bus.stream_ack &&
                     (io_bus.stream_width > 4'd13);
        w_buf_cons = r_buf;
        w_cnt_cons = r_cnt;
        if (w_consume) begin
            w_buf_cons = r_buf << io_bus.stream_width;
            w_cnt_cons = (w_width_ext >= r_cnt) ? 7'd0 : (r_cnt - w_width_ext);
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (io_bus.ce_decode) w_state_next = S_RUN;
            S_RUN: begin
                if (io_bus.all_end)  w_state_next = S_DONE;
                else if (w_last_acc) w_state_next = S_DRAIN;
            end
            S_DRAIN: if (io_bus.all_end) w_state_next = S_DONE;
            S_DONE:  if (!io_bus.ce_decode) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FSM outputs: refill strobe depends on the post-consume count so a word
    // can be taken in the same cycle that bits are retired (no bubble).
    always_comb begin
        w_in_ack   = !rst && (r_state == S_RUN) && io_bus.in_valid &&
                     (w_cnt_cons <= 7'd32);
        w_last_acc = w_in_ack && io_bus.in_last;
    end

    // Refill, window validity and END flush
    always_comb begin
        w_buf_next = w_buf_cons;
        w_cnt_next = w_cnt_cons;
        if (w_in_ack) begin
            // Place the new word directly below the remaining valid bits.
            w_buf_next = w_buf_cons | ({io_bus.in_data, 32'h0000_0000} >> w_cnt_cons);
            w_cnt_next = w_cnt_cons + 7'd32;
        end
        // Once no more words will arrive, a partial (zero-padded) window is
        // still usable.
        w_valid_next = (w_cnt_next >= 7'd13) ||
                       (((r_state == S_DRAIN) || w_last_acc) && (w_cnt_next != 7'd0));
        w_err_next   = r_err | w_illegal;
        if (!w_active || io_bus.all_end) begin
            w_buf_next   = 64'd0;
            w_cnt_next   = 7'd0;
            w_valid_next = 1'b0;
        end
        if (r_state == S_IDLE) begin
            w_err_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf   <= 64'd0;
            r_cnt   <= 7'd0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_buf   <= w_buf_next;
            r_cnt   <= w_cnt_next;
            r_valid <= w_valid_next;
            r_err   <= w_err_next;
        end
    end

`ifdef DECODE_SHIFT_STAT_EN
    logic [31:0] r_bit_total;
    logic [32:0] w_total_sum;

    assign w_total_sum = {1'b0, r_bit_total} + {29'd0, io_bus.stream_width};

    always_ff @(posedge clk) begin
        if (rst || (r_state == S_IDLE)) begin
            r_bit_total <= 32'd0;
        end else if (w_consume) begin
            r_bit_total <= w_total_sum[32] ? 32'hFFFF_FFFF : w_total_sum[31:0];
        end
    end

    assign io_bus.bit_total = r_bit_total;
`else
    assign io_bus.bit_total = 32'd0;
`endif

    assign io_bus.in_ack       = w_in_ack;
    assign io_bus.stream_data  = r_buf[63:51];
    assign io_bus.stream_valid = r_valid;
    assign io_bus.stream_err   = r_err;

endmodule

// File: tb/tb_decode_shift.sv
// -----------------------------------------------------------------------------
// tb_decode_shift
// Drives decode_shift from a queue-backed FIFO model and random decoder acks.
// A bit-queue reference model predicts the window, valid, error, bit counter
// and FIFO strobe every cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_decode_shift;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_shift_if bus ();

    decode_shift dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int          total = 0;
    int          bad   = 0;
    bit          chk_en = 1'b0;
    logic [32:0] fifo[$];        // {last, data}
    bit          stall = 1'b0;
    logic        last_in_ack;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; returns 1 time unit after the rising edge.
    task automatic step(input bit ce, input bit sack, input int w, input bit aend);
        @(negedge clk);
        bus.ce_decode    = ce;
        bus.stream_ack   = sack;
        bus.stream_width = w[3:0];
        bus.all_end      = aend;
        bus.in_valid     = (fifo.size() > 0) && !stall;
        bus.in_data      = (fifo.size() > 0) ? fifo[0][31:0] : 32'h0;
        bus.in_last      = (fifo.size() > 0) ? fifo[0][32] : 1'b0;
        #1;
        last_in_ack = bus.in_ack;
        if (bus.in_ack && fifo.size() > 0) void'(fifo.pop_front());
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    int          m_mode;      // 0 idle, 1 run, 2 drain, 3 done
    bit          m_q[$];      // unconsumed stream bits, oldest first
    bit          m_valid;
    bit          m_err;
    logic [31:0] m_total;

    function automatic logic [12:0] m_window();
        logic [12:0] r;
        r = '0;
        for (int i = 0; i < 13; i++)
            if (i < m_q.size()) r[12-i] = m_q[i];
        return r;
    endfunction

    initial begin
        m_mode = 0; m_valid = 0; m_err = 0; m_total = 0;
        forever begin
            int  w, n;
            bit  act, cons, ill, pa;
            @(negedge clk);
            #2;
            w    = int'(bus.stream_width);
            act  = (m_mode == 1) || (m_mode == 2);
            cons = act && bus.stream_ack && m_valid && (w <= 13);
            ill  = act && bus.stream_ack && (w > 13);
            n    = m_q.size();
            if (cons) n = (w >= n) ? 0 : n - w;
            pa   = !rst && (m_mode == 1) && bus.in_valid && (n <= 32);
            if (chk_en) begin
                chk("stream_data",  32'(bus.stream_data), 32'(m_window()));
                chk("stream_valid", 32'(bus.stream_valid), 32'(m_valid));
                chk("stream_err",   32'(bus.stream_err), 32'(m_err));
                chk("bit_total",    bus.bit_total, m_total);
                chk("in_ack",       32'(bus.in_ack), 32'(pa));
            end
            if (rst) begin
                m_mode = 0; m_q.delete(); m_valid = 0; m_err = 0; m_total = 0;
            end else begin
                case (m_mode)
                    0: begin
                        m_q.delete(); m_valid = 0; m_err = 0; m_total = 0;
                        if (bus.ce_decode) m_mode = 1;
                    end
                    1, 2: begin
                        if (cons) begin
                            longint s;
                            repeat (w) if (m_q.size() > 0) void'(m_q.pop_front());
`ifdef DECODE_SHIFT_STAT_EN
                            s = longint'(m_total) + w;
                            m_total = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
`else
                            s = 0;
`endif
                        end
                        if (ill) m_err = 1;
                        if (pa) for (int b = 31; b >= 0; b--) m_q.push_back(bus.in_data[b]);
                        if (bus.all_end) begin
                            m_q.delete(); m_valid = 0; m_mode = 3;
                        end else begin
                            m_valid = (m_q.size() >= 13) ||
                                      (((m_mode == 2) || (pa && bus.in_last)) && (m_q.size() > 0));
                            if (pa && bus.in_last) m_mode = 2;
                        end
                    end
                    default: begin
                        m_valid = 0; m_q.delete();
                        if (!bus.ce_decode) m_mode = 0;
                    end
                endcase
            end
        end
    end

    // Expected counter values for the tail sequence depend on the build.
`ifdef DECODE_SHIFT_STAT_EN
    localparam logic [31:0] EXP_T26 = 32'd26;
    localparam logic [31:0] EXP_T32 = 32'd32;
`else
    localparam logic [31:0] EXP_T26 = 32'd0;
    localparam logic [31:0] EXP_T32 = 32'd0;
`endif

    task automatic finish_stream();
        step(1, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        fifo.delete();
        stall = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        bus.ce_decode = 0; bus.in_data = 0; bus.in_valid = 0; bus.in_last = 0;
        bus.stream_width = 0; bus.stream_ack = 0; bus.all_end = 0;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("rst_data",  32'(bus.stream_data), 32'h0);
        chk("rst_valid", 32'(bus.stream_valid), 32'h0);
        chk("rst_err",   32'(bus.stream_err), 32'h0);
        chk("rst_total", bus.bit_total, 32'h0);
        chk("rst_in_ack", 32'(bus.in_ack), 32'h0);

        // Basic window and start-up latency
        fifo.push_back({1'b0, 32'h1234_5678});
        fifo.push_back({1'b0, 32'h9ABC_DEF0});
        step(1, 0, 0, 0);
        chk("startup_ack_N", 32'(last_in_ack), 32'h0);
        step(1, 0, 0, 0);
        chk("startup_ack_N1", 32'(last_in_ack), 32'h1);
        chk("first_valid", 32'(bus.stream_valid), 32'h1);
        chk("basic_window", 32'(bus.stream_data), 32'h0246);
        step(1, 1, 9, 0);
        chk("after_ack9", 32'(bus.stream_data), 32'h0D15);
        finish_stream();

        // END word and END flush
        fifo.push_back({1'b1, 32'hC000_0000});
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("end_valid", 32'(bus.stream_valid), 32'h1);
        chk("end_window", 32'(bus.stream_data), 32'h1800);
        fifo.push_back({1'b0, 32'h1111_1111});
        step(1, 0, 0, 1);
        chk("done_valid", 32'(bus.stream_valid), 32'h0);
        step(1, 0, 0, 0);
        chk("done_no_ack", 32'(last_in_ack), 32'h0);
        finish_stream();

        // Tail padding plus illegal width
        fifo.push_back({1'b1, 32'hFFFF_FFFF});
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 13, 0);
        step(1, 1, 13, 0);
        chk("tail_window", 32'(bus.stream_data), 32'h1F80);
        chk("tail_valid", 32'(bus.stream_valid), 32'h1);
        step(1, 1, 14, 0);
        chk("illegal_err", 32'(bus.stream_err), 32'h1);
        chk("illegal_data", 32'(bus.stream_data), 32'h1F80);
        chk("illegal_total", bus.bit_total, EXP_T26);
        step(1, 1, 6, 0);
        chk("tail_empty", 32'(bus.stream_valid), 32'h0);
        chk("tail_total", bus.bit_total, EXP_T32);
        finish_stream();
        chk("err_cleared", 32'(bus.stream_err), 32'h0);

        // Refill straddle with continuous width-13 acks
        for (int i = 0; i < 3; i++) fifo.push_back({1'b0, $urandom()});
        step(1, 0, 0, 0);
        repeat (10) step(1, 1, 13, 0);
        finish_stream();

        // Reset mid-stream at 40 buffered bits, then restart
        for (int i = 0; i < 3; i++) fifo.push_back({1'b0, $urandom()});
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 13, 0);
        step(1, 1, 11, 0);
        rst = 1'b1;
        step(1, 1, 5, 0);
        rst = 1'b0;
        chk("mrst_data",  32'(bus.stream_data), 32'h0);
        chk("mrst_valid", 32'(bus.stream_valid), 32'h0);
        chk("mrst_err",   32'(bus.stream_err), 32'h0);
        chk("mrst_total", bus.bit_total, 32'h0);
        fifo.delete();
        fifo.push_back({1'b0, 32'hA5A5_A5A5});
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("restart_valid", 32'(bus.stream_valid), 32'h1);
        chk("restart_window", 32'(bus.stream_data), 32'h14B4);
        finish_stream();

        // Randomized streams
        for (int s = 0; s < 12; s++) begin
            int nw, cyc;
            nw = $urandom_range(1, 6);
            for (int i = 0; i < nw; i++)
                fifo.push_back({(i == nw - 1) && ($urandom_range(0, 1) == 1), $urandom()});
            cyc = $urandom_range(40, 150);
            for (int c = 0; c < cyc; c++) begin
                int w;
                stall = ($urandom_range(0, 3) == 0);
                w = ($urandom_range(0, 19) == 0) ? 14 + $urandom_range(0, 1)
                                                 : $urandom_range(0, 13);
                rst = ($urandom_range(0, 199) == 0);
                step(1, $urandom_range(0, 2) != 0, w, 0);
                rst = 1'b0;
            end
            stall = 1'b0;
            finish_stream();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
